// File: rtl/stopwatch_pkg.sv
// Shared constants and types for the stopwatch counter: BCD limits, FSM
// state encoding and adjust-field select values.
package stopwatch_pkg;

    localparam int DIGIT_W = 4;

    typedef logic [DIGIT_W-1:0] bcd_t;

    localparam bcd_t SEC_TENS_MAX = 4'd5;
    localparam bcd_t MIN_TENS_MAX = 4'd5;
    localparam bcd_t ONES_MAX     = 4'd9;

    typedef enum logic {
        RUN    = 1'b0,
        PAUSED = 1'b1
    } state_t;

    localparam logic SEL_MIN = 1'b0;
    localparam logic SEL_SEC = 1'b1;

endpackage

// File: rtl/stopwatch_counter_if.sv
// Control inputs and display outputs of the stopwatch counter. The master side
// (tick selector / buttons / display) drives the controls; the slave side is
// the counter itself.
interface stopwatch_counter_if;
    import stopwatch_pkg::*;

    logic tick_in;
    logic adj;
    logic sel;
    logic pause_pulse;
    bcd_t min_tens;
    bcd_t min_ones;
    bcd_t sec_tens;
    bcd_t sec_ones;
    logic paused;
    logic rollover;

    modport master (
        output tick_in, adj, sel, pause_pulse,
        input  min_tens, min_ones, sec_tens, sec_ones, paused, rollover
    );

    modport slave (
        input  tick_in, adj, sel, pause_pulse,
        output min_tens, min_ones, sec_tens, sec_ones, paused, rollover
    );

endinterface

// File: rtl/stopwatch_counter_bcd_mod60.sv
// Two-digit BCD counter 00..59. wrap is combinational so the caller can carry
// into the next field on the same edge.
module bcd_mod60
    import stopwatch_pkg::*;
#(
    parameter bcd_t TENS_MAX = SEC_TENS_MAX
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    output bcd_t tens,
    output bcd_t ones,
    output logic wrap
);

    bcd_t r_tens;
    bcd_t r_ones;
    logic w_at_max;

    assign w_at_max = (r_tens >= TENS_MAX) && (r_ones >= ONES_MAX);
    assign wrap     = inc && w_at_max;
    assign tens     = r_tens;
    assign ones     = r_ones;

    // Ones count 0..9 and carry into tens; tens wrap to 0 past TENS_MAX.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tens <= '0;
            r_ones <= '0;
        end else if (inc) begin
            if (r_ones >= ONES_MAX) begin
                r_ones <= '0;
                r_tens <= (r_tens >= TENS_MAX) ? '0 : r_tens + 4'd1;
            end else begin
                r_ones <= r_ones + 4'd1;
            end
        end
    end

endmodule

// File: rtl/stopwatch_counter.sv
// Stopwatch MM:SS BCD counter. Counts rising edges of the slow tick in normal
// mode, steps a single field in adjust mode, and toggles RUN/PAUSED on
// pause_pulse. Define STOPWATCH_TICK_SYNC_EN to pass tick_in through a
// 2-flop synchroniser before edge detection.
module stopwatch_counter
    import stopwatch_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    stopwatch_counter_if.slave   bus
);

    logic   w_tick;
    logic   w_tick_vld;
    logic   r_tick_d;
    logic   r_armed;
    logic   w_tick_ev;
    state_t r_state;
    state_t w_state_nxt;
    logic   w_sec_inc;
    logic   w_min_inc;
    logic   w_sec_wrap;
    logic   w_min_wrap;
    logic   r_rollover;
    bcd_t   w_sec_tens;
    bcd_t   w_sec_ones;
    bcd_t   w_min_tens;
    bcd_t   w_min_ones;

`ifdef STOPWATCH_TICK_SYNC_EN
    logic [1:0] r_sync;
    logic [1:0] r_vld_pipe;

    // Two-flop synchroniser; the valid pipe marks when its output holds a real
    // post-reset sample so reset-value zeros cannot arm edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync     <= '0;
            r_vld_pipe <= '0;
        end else begin
            r_sync     <= {r_sync[0], bus.tick_in};
            r_vld_pipe <= {r_vld_pipe[0], 1'b1};
        end
    end

    assign w_tick     = r_sync[1];
    assign w_tick_vld = r_vld_pipe[1];
`else
    assign w_tick     = bus.tick_in;
    assign w_tick_vld = 1'b1;
`endif

    // Delayed copy for edge detect; arm only once a genuine low has been seen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick_d <= 1'b0;
            r_armed  <= 1'b0;
        end else begin
            r_tick_d <= w_tick & w_tick_vld;
            r_armed  <= r_armed | (w_tick_vld & ~w_tick);
        end
    end

    assign w_tick_ev = w_tick & w_tick_vld & ~r_tick_d & r_armed;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= RUN;
        else        r_state <= w_state_nxt;
    end

    // Next state: pause_pulse toggles regardless of mode.
    always_comb begin
        w_state_nxt = r_state;
        if (bus.pause_pulse) begin
            case (r_state)
                RUN:     w_state_nxt = PAUSED;
                PAUSED:  w_state_nxt = RUN;
                default: w_state_nxt = RUN;
            endcase
        end
    end

    // Increment gating uses the pre-toggle state, so a coincident pulse and
    // tick is judged by the state the tick arrived in.
    assign w_sec_inc = w_tick_ev & (bus.adj ? (bus.sel == SEL_SEC) : (r_state == RUN));
    assign w_min_inc = w_tick_ev & (bus.adj ? (bus.sel == SEL_MIN)
                                            : ((r_state == RUN) & w_sec_wrap));

    bcd_mod60 #(.TENS_MAX(SEC_TENS_MAX)) u_sec (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_sec_inc),
        .tens  (w_sec_tens),
        .ones  (w_sec_ones),
        .wrap  (w_sec_wrap)
    );

    bcd_mod60 #(.TENS_MAX(MIN_TENS_MAX)) u_min (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_min_inc),
        .tens  (w_min_tens),
        .ones  (w_min_ones),
        .wrap  (w_min_wrap)
    );

    // Minutes can only wrap by carry in normal mode, which is the 59:59 rollover.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_rollover <= 1'b0;
        else        r_rollover <= ~bus.adj & w_min_wrap;
    end

    assign bus.min_tens = w_min_tens;
    assign bus.min_ones = w_min_ones;
    assign bus.sec_tens = w_sec_tens;
    assign bus.sec_ones = w_sec_ones;
    assign bus.paused   = (r_state == PAUSED);
    assign bus.rollover = r_rollover;

endmodule

// File: doc/stopwatch_counter.md
# stopwatch_counter

Time-keeping core of the stopwatch, directly downstream of the 1 Hz / 2 Hz tick selector. It consumes the selected slow tick as a level signal and advances a BCD MM:SS count from 00:00 to 59:59 in normal mode. In adjust mode it instead steps the selected field (minutes or seconds) independently. Handles pause/resume and feeds the 7-segment display driver with four BCD digits.

## Interface
- No parameters; all limits are constants in `stopwatch_pkg`.
- `clk`  in  1  system clock; all state on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `tick_in`  in  1  selected slow tick (square wave, 1 Hz normal / 2 Hz adjust); each rising edge is one count event
- `adj`  in  1  1 = adjust mode, 0 = normal mode; debounced, synchronous to `clk`
- `sel`  in  1  adjust target: 0 = minutes, 1 = seconds; debounced, synchronous
- `pause_pulse`  in  1  one-cycle debounced pulse; toggles RUN/PAUSED
- `min_tens`  out  4  BCD 0–5
- `min_ones`  out  4  BCD 0–9
- `sec_tens`  out  4  BCD 0–5
- `sec_ones`  out  4  BCD 0–9
- `paused`  out  1  1 while in PAUSED
- `rollover`  out  1  one-cycle pulse on 59:59 → 00:00

## Operation
- FSM states: RUN, PAUSED. Reset → RUN.
- `pause_pulse` = 1 toggles RUN ↔ PAUSED on that edge, in both normal and adjust modes.
- Tick event: rising edge of (synchronised) `tick_in`, detected against a delayed copy. Edge detection is armed only after the tick has been sampled low at least once since reset; a tick already high at reset release is not counted.
- Normal mode (`adj`=0), state RUN, tick event: seconds +1. Seconds wrap 59→00 with a carry of +1 into minutes. 59:59 → 00:00 with `rollover` pulse.
- Normal mode, PAUSED: tick events are discarded; digits hold.
- Adjust mode (`adj`=1): each tick event increments only the field chosen by `sel`. The field wraps 59→00 with no carry into the other field and no `rollover`. Adjust ignores PAUSED; the FSM state is retained and resumes governing on exit.
- Simultaneous `pause_pulse` and tick event: the tick is evaluated against the pre-toggle state. RUN + pulse + tick → count, then PAUSED. PAUSED + pulse + tick → no count, then RUN.
- `adj` or `sel` changes take effect on the next tick event; no partial update.
- BCD rules: ones digit 9 → 0 carries into tens; tens 5 with ones 9 → field 00. Digits never leave the BCD range listed above.

## Timing
- Reset values: all digits 0, `paused`=0, `rollover`=0, sync/edge flops 0, armed=0.
- Latency from `tick_in` rise to digit update: digits change on the 3rd rising `clk` edge that samples `tick_in` high with the synchroniser, on the 1st without it.
- `rollover` is registered and high during the cycle immediately after the edge on which the digits become 00:00.
- `paused` updates on the same edge as the toggle.
- Reset asserted mid-count clears everything asynchronously. Counting resumes only after a full low→high tick cycle.

## Configuration
- `STOPWATCH_TICK_SYNC_EN` defined: `tick_in` passes through a 2-flop synchroniser before edge detection, for use when the tick comes from a derived clock.
- Undefined: `tick_in` must be synchronous to `clk`; edge detection uses it directly, with a latency of 1 edge. All other behaviour is identical.

## Structure
- `stopwatch_pkg`: BCD digit width (4), `SEC_TENS_MAX`=5, `ONES_MAX`=9, `MIN_TENS_MAX`=5, FSM state enum {RUN, PAUSED}, `SEL_MIN`/`SEL_SEC` constants.
- Sub-module `bcd_mod60`: two-digit BCD 00–59 counter with inputs `inc` and outputs `tens`, `ones`, `wrap` (high when incrementing from 59). Two instances, seconds and minutes. The top level gates `inc` according to mode and carry.

## Test plan
- Reset, RUN, 60 ticks at 1 Hz → digits go 00:00 … 00:59 → 01:00. `rollover` stays 0.
- Preload to 59:58 via adjust, exit adjust, 2 ticks → 59:59, then 00:00 with `rollover`=1 for exactly one cycle.
- At 00:05, `pause_pulse`, then 10 ticks → holds 00:05 with `paused`=1. Second pulse, then 1 tick → 00:06.
- `adj`=1, `sel`=1 from 00:58, 3 ticks → 00:59, 00:00, 00:01. Minutes unchanged, no `rollover`. `sel`=0 from 59:01, 1 tick → 00:01.
- `pause_pulse` coincident with a tick event in RUN at 00:10 → 00:11 and `paused`=1. Coincident again in PAUSED → stays 00:11, `paused`=0.
- `tick_in` held high through reset release → no count until it goes low and high again. Reset asserted at 12:34 mid-run → 00:00 immediately, asynchronously. Check latency of 3 vs 1 edges with and without the macro defined.
